vga_timing_gen: RTL

- Generates the raster for the display path: horizontal and vertical pixel counters, DrawX/DrawY, the `blank` display-enable and active-low sync pulses, plus line/frame markers and a frame counter.
- Sits directly upstream of the sprite/palette image stages. Those stages consume DrawX, DrawY and `blank` and register colour one `vga_clk` later.
- Sync outputs carry a configurable delay so they stay aligned with that registered colour.

---
 rtl/vga_timing_pkg.sv | 19 +
 rtl/vga_timing_if.sv | 25 ++
 rtl/vga_axis_counter.sv | 52 +++++
 rtl/vga_timing_gen.sv | 107 ++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared raster constants and types for the VGA timing generator.
// The defaults describe 640x480@60 with an 800x525 total raster.
package vga_timing_pkg;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FRONT   = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BACK    = 48;
  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FRONT   = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BACK    = 33;

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  typedef logic [9:0] coord_t;

endpackage

// File: rtl/vga_timing_if.sv
// Raster bundle between the timing generator (master) and the image stages (slave).
interface vga_timing_if;
  import vga_timing_pkg::*;

  logic       clk_en;
  coord_t     DrawX;
  coord_t     DrawY;
  logic       blank;
  logic       hs;
  logic       vs;
  logic       line_start;
  logic       frame_start;
  logic [7:0] frame_count;

  modport master (
    input  clk_en,
    output DrawX, DrawY, blank, hs, vs, line_start, frame_start, frame_count
  );

  modport slave (
    output clk_en,
    input  DrawX, DrawY, blank, hs, vs, line_start, frame_start, frame_count
  );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus decodes of the value it is about to take.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned VISIBLE = 640,
  parameter int unsigned FRONT   = 16,
  parameter int unsigned SYNC    = 96,
  parameter int unsigned BACK    = 48
) (
  input  logic   vga_clk,
  input  logic   reset_n,
  input  logic   step,
  output coord_t count,
  output coord_t next_count,
  output logic   wrap,
  output logic   active,
  output logic   sync_n
);

  localparam int unsigned Total = VISIBLE + FRONT + SYNC + BACK;
  localparam coord_t Last    = coord_t'(Total - 1);
  localparam coord_t VisEnd  = coord_t'(VISIBLE);
  localparam coord_t SyncBeg = coord_t'(VISIBLE + FRONT);
  localparam coord_t SyncEnd = coord_t'(VISIBLE + FRONT + SYNC);

  coord_t count_q;

  assign wrap = (count_q == Last);

  always_comb begin
    next_count = count_q;
    if (step) begin
      next_count = wrap ? '0 : count_q + coord_t'(1);
    end
  end

  // Decodes look at next_count so the parent can register them in step with count.
  assign active = (next_count < VisEnd);
  assign sync_n = !((next_count >= SyncBeg) && (next_count < SyncEnd));

  // Reset parks at the last position so the first step lands on 0.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= Last;
    end else begin
      count_q <= next_count;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator: pixel/line counters, blank and marker decodes, delayed active-low syncs
// and a frame counter, all advancing only on clk_en.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE  = vga_timing_pkg::H_VISIBLE,
  parameter int unsigned H_FRONT    = vga_timing_pkg::H_FRONT,
  parameter int unsigned H_SYNC     = vga_timing_pkg::H_SYNC,
  parameter int unsigned H_BACK     = vga_timing_pkg::H_BACK,
  parameter int unsigned V_VISIBLE  = vga_timing_pkg::V_VISIBLE,
  parameter int unsigned V_FRONT    = vga_timing_pkg::V_FRONT,
  parameter int unsigned V_SYNC     = vga_timing_pkg::V_SYNC,
  parameter int unsigned V_BACK     = vga_timing_pkg::V_BACK,
  parameter int unsigned SYNC_DELAY = 1
) (
  input logic         vga_clk,
  input logic         reset_n,
  vga_timing_if.master vga
);
  import vga_timing_pkg::*;

  localparam int unsigned HTotal = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned VTotal = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  if (HTotal > 1024 || VTotal > 1024 || SYNC_DELAY > 3) begin : g_param_check
    $error("vga_timing_gen: totals must be <= 1024 and SYNC_DELAY <= 3");
  end

  coord_t h_count, h_next, v_count, v_next;
  logic   h_wrap, v_wrap, h_active, v_active, h_sync_n, v_sync_n;
  logic   v_step;

  assign v_step = vga.clk_en && h_wrap;

  vga_axis_counter #(
    .VISIBLE(H_VISIBLE),
    .FRONT  (H_FRONT),
    .SYNC   (H_SYNC),
    .BACK   (H_BACK)
  ) u_h_counter (
    .vga_clk   (vga_clk),
    .reset_n   (reset_n),
    .step      (vga.clk_en),
    .count     (h_count),
    .next_count(h_next),
    .wrap      (h_wrap),
    .active    (h_active),
    .sync_n    (h_sync_n)
  );

  vga_axis_counter #(
    .VISIBLE(V_VISIBLE),
    .FRONT  (V_FRONT),
    .SYNC   (V_SYNC),
    .BACK   (V_BACK)
  ) u_v_counter (
    .vga_clk   (vga_clk),
    .reset_n   (reset_n),
    .step      (v_step),
    .count     (v_count),
    .next_count(v_next),
    .wrap      (v_wrap),
    .active    (v_active),
    .sync_n    (v_sync_n)
  );

  logic                  blank_q, line_start_q, frame_start_q;
  logic [7:0]            frame_count_q;
  logic [SYNC_DELAY:0]   hs_pipe_q, vs_pipe_q, hs_pipe_d, vs_pipe_d;

  // Stage 0 is already aligned with DrawX; each further stage adds one enabled cycle.
  if (SYNC_DELAY == 0) begin : g_no_delay
    assign hs_pipe_d = h_sync_n;
    assign vs_pipe_d = v_sync_n;
  end else begin : g_delay
    assign hs_pipe_d = {hs_pipe_q[SYNC_DELAY-1:0], h_sync_n};
    assign vs_pipe_d = {vs_pipe_q[SYNC_DELAY-1:0], v_sync_n};
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      blank_q       <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
      hs_pipe_q     <= '1;
      vs_pipe_q     <= '1;
    end else if (vga.clk_en) begin
      blank_q       <= h_active && v_active;
      line_start_q  <= (h_next == '0);
      frame_start_q <= (h_next == '0) && (v_next == '0);
      if (h_wrap && v_wrap) begin
        frame_count_q <= frame_count_q + 8'd1;
      end
      hs_pipe_q     <= hs_pipe_d;
      vs_pipe_q     <= vs_pipe_d;
    end
  end

  assign vga.DrawX       = h_count;
  assign vga.DrawY       = v_count;
  assign vga.blank       = blank_q;
  assign vga.hs          = hs_pipe_q[SYNC_DELAY];
  assign vga.vs          = vs_pipe_q[SYNC_DELAY];
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;
  assign vga.frame_count = frame_count_q;

endmodule
